io_uart_in: RTL

//  Receive-side IO peripheral on the dma_io bus: buffers characters delivered by the UART RX path in a FIFO.
//  CPU pops the characters with load instructions; status and an interrupt request are provided.

---
 rtl/io_uart_in_pkg.sv | 24 ++
 rtl/io_uart_in_fifo.sv | 61 ++++++
 rtl/io_uart_in.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/io_uart_in_pkg.sv
// Shared definitions for the UART receive peripheral: register map,
// register-select encoding and the interrupt threshold helper.
package io_uart_in_pkg;

  localparam int DEPTH_LOG2_DEF = 4;

  // Word addresses (byte address >> 2) on the dma_io bus.
  localparam logic [13:0] ADR_RXDATA_DEF = 14'h3204;
  localparam logic [13:0] ADR_STATUS_DEF = 14'h3205;
  localparam logic [13:0] ADR_CTRL_DEF   = 14'h3206;

  typedef enum logic [1:0] {
    SEL_NONE   = 2'd0,
    SEL_RXDATA = 2'd1,
    SEL_STATUS = 2'd2,
    SEL_CTRL   = 2'd3
  } reg_sel_e;

  // A zero threshold means "interrupt on any pending character".
  function automatic logic [3:0] eff_thresh(input logic [3:0] thresh);
    return (thresh == 4'd0) ? 4'd1 : thresh;
  endfunction

endpackage

// File: rtl/io_uart_in_fifo.sv
// Generic synchronous 8-bit FIFO with a combinational head output.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module io_uart_in_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [7:0]            din,
  output logic [7:0]            dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic                  do_pop;
  logic                  do_push;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; validity is tracked by the pointers and
  // count, and leaving it unreset lets it map onto plain RAM/flops without a reset tree.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/io_uart_in.sv
// UART receive peripheral on the dma_io bus: buffers received characters,
// exposes RXDATA/STATUS/CTRL and drives a level interrupt request.
module io_uart_in
  import io_uart_in_pkg::*;
#(
  parameter int          DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter logic [13:0] ADR_RXDATA = ADR_RXDATA_DEF,
  parameter logic [13:0] ADR_STATUS = ADR_STATUS_DEF,
  parameter logic [13:0] ADR_CTRL   = ADR_CTRL_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dma_io_we,
  input  logic [13:0] dma_io_wadr,
  input  logic [31:0] dma_io_wdata,
  input  logic [13:0] dma_io_radr,
  input  logic        dma_io_radr_en,
  input  logic [31:0] dma_io_rdata_in,
  output logic [31:0] dma_io_rdata,
  input  logic [7:0]  uart_rx_char,
  input  logic        uart_rx_we,
  output logic        rx_int
);

  localparam logic [DEPTH_LOG2:0] CNT_ONE = (DEPTH_LOG2 + 1)'(1);

  reg_sel_e             rd_sel;
  logic                 wr_status;
  logic                 wr_ctrl;
  logic                 flush;
  logic                 pop_req;
  logic                 pop_ok;
  logic                 push_ok;
  logic                 push_drop;
  logic [7:0]           head;
  logic                 full;
  logic                 empty;
  logic [DEPTH_LOG2:0]  count;
  logic [DEPTH_LOG2:0]  count_next;

  logic                 ovf;
  logic                 ovf_next;
  logic                 ie;
  logic [3:0]           thresh;
  logic                 hit_q;
  logic [31:0]          rdata_q;
  logic [31:0]          rdata_next;
  logic                 int_next;

  // Read-side decode; writes are decoded separately so a same-cycle write
  // never alters what the read captures.
  always_comb begin
    rd_sel = SEL_NONE;
    if (dma_io_radr_en) begin
      if (dma_io_radr == ADR_RXDATA)      rd_sel = SEL_RXDATA;
      else if (dma_io_radr == ADR_STATUS) rd_sel = SEL_STATUS;
      else if (dma_io_radr == ADR_CTRL)   rd_sel = SEL_CTRL;
    end
  end

  assign wr_status = dma_io_we & (dma_io_wadr == ADR_STATUS);
  assign wr_ctrl   = dma_io_we & (dma_io_wadr == ADR_CTRL);
  assign flush     = wr_ctrl & dma_io_wdata[1];

  assign pop_req   = (rd_sel == SEL_RXDATA);
  assign pop_ok    = pop_req & ~empty;
  // A flushed push is discarded silently rather than counted as an overflow.
  assign push_ok   = uart_rx_we & ~flush & (~full | pop_ok);
  assign push_drop = uart_rx_we & ~flush & full & ~pop_ok;

  io_uart_in_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (uart_rx_we),
    .pop   (pop_req),
    .flush (flush),
    .din   (uart_rx_char),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // NOTE: every signal driven from always_comb gets a default first so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else begin
      unique case ({push_ok, pop_ok})
        2'b10:   count_next = count + CNT_ONE;
        2'b01:   count_next = count - CNT_ONE;
        default: count_next = count;
      endcase
    end
  end

  // Overflow is sticky; a new drop in the same cycle as a clear wins.
  assign ovf_next = (ovf & ~(wr_status & dma_io_wdata[7])) | push_drop;
  assign int_next = ie & ((count_next >= (DEPTH_LOG2 + 1)'(eff_thresh(thresh))) | ovf_next);

  always_comb begin
    rdata_next = 32'd0;
    unique case (rd_sel)
      SEL_RXDATA: rdata_next = empty ? 32'd0 : {23'd0, 1'b1, head};
      SEL_STATUS: rdata_next = {24'd0, ovf, full, empty, 5'(count)};
      SEL_CTRL:   rdata_next = {24'd0, thresh, 3'b000, ie};
      default:    rdata_next = 32'd0;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf     <= 1'b0;
      ie      <= 1'b0;
      thresh  <= 4'd0;
      hit_q   <= 1'b0;
      rdata_q <= 32'd0;
      rx_int  <= 1'b0;
    end else begin
      ovf    <= ovf_next;
      rx_int <= int_next;
      hit_q  <= (rd_sel != SEL_NONE);
      if (rd_sel != SEL_NONE) rdata_q <= rdata_next;
      if (wr_ctrl) begin
        ie     <= dma_io_wdata[0];
        thresh <= dma_io_wdata[7:4];
      end
    end
  end

  assign dma_io_rdata = hit_q ? rdata_q : dma_io_rdata_in;

  logic unused_wdata;
  assign unused_wdata = ^{dma_io_wdata[31:8], dma_io_wdata[3:2]};

endmodule
